// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMips control path.
//   stage_t    : 2-bit stage code seen by the instruction decoder
//   STAGE_LAST : final stage of an instruction, where PCHold can stall
package picomips_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WRITE  = 2'd3
    } stage_t;

    localparam stage_t STAGE_LAST = S_WRITE;

endpackage

// File: rtl/handshake_debounce.sv
// Synchroniser plus debouncer for the board handshake switch.
// Ports:
//   clk      : system clock, rising edge
//   n_reset  : asynchronous active-low reset
//   raw_i    : asynchronous switch level
//   level_o  : synchronised, debounced level
module handshake_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic n_reset,
    input  logic raw_i,
    output logic level_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;

    // Bit 0 takes the raw input; the MSB is the metastability-safe copy.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // The counter measures how long sync has disagreed with the output;
    // any agreement restarts it, so short glitches never reach the output.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DB_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the picoMips core.
// Ports:
//   clk           : system clock, rising edge
//   n_reset       : asynchronous active-low reset
//   run           : 1 = advance stages, 0 = freeze stage counter
//   handshake_raw : asynchronous handshake switch
//   pc_hold       : decoder PCHold, only meaningful in the last stage
//   stage         : current stage code to the decoder
//   handshake     : synchronised/debounced handshake to the decoder
//   ir_load       : instruction register load strobe
//   pc_en         : program counter advance strobe (one per instruction)
//   stalled       : high while held in the last stage by pc_hold
//   instr_count   : retired-instruction counter, wraps
module stage_sequencer
    import picomips_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             run,
    input  logic             handshake_raw,
    input  logic             pc_hold,
    output logic [1:0]       stage,
    output logic             handshake,
    output logic             ir_load,
    output logic             pc_en,
    output logic             stalled,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;

    handshake_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .n_reset (n_reset),
        .raw_i   (handshake_raw),
        .level_o (handshake)
    );

    assign at_last = (stage_q == STAGE_LAST);

    // Strobes are gated by n_reset so they read low for the whole reset
    // window, not just after the registers have cleared.
    assign ir_load = n_reset && run && (stage_q == S_FETCH);
    assign pc_en   = n_reset && run && at_last && !pc_hold;
    assign stalled = n_reset && run && at_last && pc_hold;

    always_comb begin
        stage_d = stage_q;
        if (run) begin
            if (!at_last) begin
                stage_d = stage_t'(stage_q + 2'd1);
            end else if (!pc_hold) begin
                stage_d = S_FETCH;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stage_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stage       = stage_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int CW    = 8;
    localparam int CMOD  = 1 << CW;

    logic          clk = 1'b0;
    logic          n_reset = 1'b1;
    logic          run = 1'b0;
    logic          handshake_raw = 1'b0;
    logic          pc_hold = 1'b0;
    logic [1:0]    stage;
    logic          handshake;
    logic          ir_load;
    logic          pc_en;
    logic          stalled;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    stage_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .run           (run),
        .handshake_raw (handshake_raw),
        .pc_hold       (pc_hold),
        .stage         (stage),
        .handshake     (handshake),
        .ir_load       (ir_load),
        .pc_en         (pc_en),
        .stalled       (stalled),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: instruction position, retire count, and a raw-sample
    // delay line feeding a "how long has it disagreed" run-length debounce.
    int m_stage;
    int m_count;
    bit m_hs;
    int m_run_len;
    bit m_sq[$];
    int seen_stall;
    int seen_pcen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage   = 0;
        m_count   = 0;
        m_hs      = 1'b0;
        m_run_len = 0;
        m_sq      = {};
        for (int i = 0; i < SYNC; i++) m_sq.push_back(1'b0);
    endtask

    function automatic bit exp_ir();
        return n_reset && run && (m_stage == 0);
    endfunction
    function automatic bit exp_pc();
        return n_reset && run && (m_stage == 3) && !pc_hold;
    endfunction
    function automatic bit exp_st();
        return n_reset && run && (m_stage == 3) && pc_hold;
    endfunction

    // Applied once per rising edge, with the inputs as they were before it.
    task automatic model_step();
        bit s;
        s = m_sq[0];
        if (exp_pc()) m_count = (m_count + 1) % CMOD;
        if (run) begin
            if (m_stage < 3) m_stage = m_stage + 1;
            else if (!pc_hold) m_stage = 0;
        end
        if (s != m_hs) begin
            m_run_len++;
            if (m_run_len == DEB) begin
                m_hs      = s;
                m_run_len = 0;
            end
        end else begin
            m_run_len = 0;
        end
        m_sq.push_back(handshake_raw);
        void'(m_sq.pop_front());
    endtask

    task automatic check_all();
        chk("stage",     32'(stage),       32'(m_stage));
        chk("ir_load",   32'(ir_load),     32'(exp_ir()));
        chk("pc_en",     32'(pc_en),       32'(exp_pc()));
        chk("stalled",   32'(stalled),     32'(exp_st()));
        chk("handshake", 32'(handshake),   32'(m_hs));
        chk("count",     32'(instr_count), 32'(m_count));
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        check_all();
        if (stalled) seen_stall++;
        if (pc_en)   seen_pcen++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int g;
        logic [CW-1:0] c0;

        // Reset asserted mid-cycle, held over two edges.
        #2 n_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        n_reset = 1'b1;

        // 1: free run
        run = 1'b1; pc_hold = 1'b0;
        repeat (12) cycle();
        chk("t1_count", 32'(instr_count), 32'd3);
        chk("t1_stage", 32'(stage), 32'd0);

        // 2: stall for 5 cycles at stage 3
        repeat (3) cycle();
        chk("t2_at3", 32'(stage), 32'd3);
        c0 = instr_count;
        seen_stall = 0; seen_pcen = 0;
        pc_hold = 1'b1;
        repeat (5) cycle();
        pc_hold = 1'b0;
        cycle();
        chk("t2_stalls", 32'(seen_stall), 32'd5);
        chk("t2_pcen",   32'(seen_pcen),  32'd1);
        chk("t2_delta",  32'(CW'(instr_count - c0)), 32'd1);
        chk("t2_wrap0",  32'(stage), 32'd0);

        // 3: debounce accept, rise and fall
        handshake_raw = 1'b1;
        lat = 0;
        while (handshake !== 1'b1 && lat < 20) begin cycle(); lat++; end
        chk("t3_rise_lat", 32'(lat), 32'(SYNC + DEB));
        handshake_raw = 1'b0;
        lat = 0;
        while (handshake !== 1'b0 && lat < 20) begin cycle(); lat++; end
        chk("t3_fall_lat", 32'(lat), 32'(SYNC + DEB));

        // 4: glitch of 3 cycles is rejected
        handshake_raw = 1'b1;
        repeat (3) cycle();
        handshake_raw = 1'b0;
        repeat (8) cycle();
        chk("t4_hs",    32'(handshake), 32'd0);
        chk("t4_dbcnt", 32'(dut.u_debounce.cnt_q), 32'd0);

        // 5: run gating at stage 2, then during a stall
        g = 0;
        while (stage != 2'd2 && g < 8) begin cycle(); g++; end
        chk("t5_at2", 32'(stage), 32'd2);
        run = 1'b0;
        repeat (4) cycle();
        chk("t5_hold2", 32'(stage), 32'd2);
        run = 1'b1;
        cycle();
        chk("t5_resume3", 32'(stage), 32'd3);
        pc_hold = 1'b1;
        cycle();
        run = 1'b0;
        repeat (2) cycle();
        #1;
        chk("t5_frz_stage", 32'(stage),   32'd3);
        chk("t5_frz_stall", 32'(stalled), 32'd0);
        chk("t5_frz_pcen",  32'(pc_en),   32'd0);
        @(negedge clk);
        run = 1'b1; pc_hold = 1'b0;
        cycle();

        // 6: counter wrap, then async reset during a stall
        g = 0;
        while (instr_count != {CW{1'b1}} && g < 2000) begin cycle(); g++; end
        chk("t6_full", 32'(instr_count), 32'(CMOD - 1));
        repeat (4) cycle();
        chk("t6_wrap", 32'(instr_count), 32'd0);
        handshake_raw = 1'b1;
        repeat (8) cycle();
        chk("t6_hs_up", 32'(handshake), 32'd1);
        pc_hold = 1'b1;
        g = 0;
        while (stage != 2'd3 && g < 8) begin cycle(); g++; end
        cycle();
        #2 n_reset = 1'b0;
        #1;
        chk("t6_rst_stage", 32'(stage),       32'd0);
        chk("t6_rst_hs",    32'(handshake),   32'd0);
        chk("t6_rst_count", 32'(instr_count), 32'd0);
        chk("t6_rst_stall", 32'(stalled),     32'd0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1; pc_hold = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) handshake_raw = ~handshake_raw;
            run     = ($urandom_range(0, 9) != 0);
            pc_hold = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle stage sequencer for the picoMips core. Generates the 2-bit Stage code consumed by the instruction decoder, and stalls in the final stage while the decoder asserts PCHold (wait-for-handshake instructions). Synchronises and debounces the external handshake switch, then feeds the clean level back to the decoder. Issues the PC-advance and instruction-register load strobes, and keeps a retired-instruction counter for debug.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on handshake_raw (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before the debounced level changes (minimum 1)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
run  input  1  1 = sequence stages; 0 = freeze the stage counter
handshake_raw  input  1  asynchronous handshake switch from the board
pc_hold  input  1  decoder PCHold; sampled only in stage 3
stage  output  2  current stage, 0..3, to decoder Stage
handshake  output  1  synchronised and debounced handshake, to decoder Handshake
ir_load  output  1  instruction register load strobe
pc_en  output  1  program counter advance strobe
stalled  output  1  high while held in stage 3 by pc_hold
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (n_reset low, asynchronous): stage=0, synchroniser flops=0, handshake=0, debounce counter=0, instr_count=0. While in reset, ir_load/pc_en/stalled=0.
- Reset release: the first active edge after n_reset rises starts normal operation. No special sequence.
- Stage register, on each clk edge:
  - run=0: stage holds its value.
  - run=1, stage 0..2: stage increments by 1.
  - run=1, stage 3, pc_hold=1: stage stays at 3 (stall).
  - run=1, stage 3, pc_hold=0: stage wraps to 0.
- Combinational strobes, decoded from the registered state:
  - ir_load = run && stage==0.
  - pc_en = run && stage==3 && !pc_hold.
  - stalled = run && stage==3 && pc_hold.
  - Exactly one pc_en per retired instruction; an instruction takes 4 cycles plus stall cycles.
- instr_count: increments on every edge where pc_en=1; wraps from 2^CNT_W-1 to 0.
- Handshake path:
  - handshake_raw passes through a SYNC_STAGES-deep flop chain; sync = last flop.
  - Debounce counter, width ceil(log2(DEBOUNCE_CYCLES))+1.
  - If sync == handshake: counter cleared.
  - Else the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 on an edge, handshake <= sync and the counter clears.
  - Net effect: handshake changes SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean edge on handshake_raw.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
  - The handshake path runs independently of run.
- Simultaneous events:
  - A handshake change that lands in the same cycle the decoder evaluates pc_hold in stage 3 takes effect on the next edge, because handshake is registered.
  - Deasserting run during a stall freezes stage=3; pc_en and stalled are forced to 0.
- Reset mid-operation (including during a stall or a debounce count) returns all state to reset values immediately. An instruction in progress is abandoned and not counted.

Decomposition:
- Shared package (picomips_pkg): typedef stage_t (2-bit enum S_FETCH=0, S_DECODE=1, S_EXEC=2, S_WRITE=3); constant STAGE_LAST=S_WRITE.
- One sub-module: handshake_debounce, holding the synchroniser plus debounce counter, with parameters SYNC_STAGES and DEBOUNCE_CYCLES.
- Stage counter and strobes stay in stage_sequencer.

Test Plan:
1. Reset and free-run. Bench parameters DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Assert n_reset low mid-cycle, release, run=1, pc_hold=0 for 12 cycles -> stage sequence 0,1,2,3,0,...; ir_load high at stage 0; pc_en high at stage 3; instr_count=3 after 12 cycles.
2. Stall. pc_hold=1 held on entry to stage 3 for 5 cycles, then 0 -> stage stays at 3 for 6 cycles; stalled=1 for 5 cycles; a single pc_en pulse; instr_count increments by exactly 1.
3. Debounce accept. handshake_raw 0->1 held -> handshake rises exactly 6 cycles later (2 sync + 4 debounce); a falling edge behaves symmetrically.
4. Glitch reject. handshake_raw high for 3 cycles then low -> handshake stays 0 throughout; debounce counter returns to 0.
5. Run gating. Deassert run at stage 2 for 4 cycles -> stage holds at 2; ir_load/pc_en stay 0; counting resumes at 3 after run=1. Also deassert run during a stall -> pc_en=0, stalled=0.
6. Wrap and async reset. Preload instr_count to 0xFFFF via forced run, then one retire -> count=0x0000. Pulse n_reset low during stage 3 stall -> stage=0, handshake=0, instr_count=0 without waiting for a clock edge.
